// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter among NUM_REQ requesters.
// Define UART_TX_ARB_LOCK_EN to add req_lock, which keeps the last grantee's multi-byte packet contiguous.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 16,
  localparam int unsigned GW          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_lock,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_busy,
  output logic [GW-1:0]        grant_id,
  output logic                 arb_busy,
  output logic                 err_timeout
);

  localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  state_e             state_q;
  logic [GW-1:0]      ptr_q;
  logic [CW-1:0]      to_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               uart_tx_en_q;
  logic [7:0]         uart_tx_data_q;
  logic [GW-1:0]      grant_id_q;
  logic               arb_busy_q;
  logic               err_timeout_q;

  logic               win_found;
  logic [GW-1:0]      win_idx;
  logic [GW-1:0]      cand;
  logic [NUM_REQ-1:0] win_onehot;
  logic [7:0]         win_data;

  // Winner: first valid requester above the pointer, wrapping; a locked last grantee overrides.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = GW'((32'(ptr_q) + off) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    if (req_lock[grant_id_q] && req_valid[grant_id_q]) begin
      win_found = 1'b1;
      win_idx   = grant_id_q;
    end
`endif
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign win_data = req_data[{win_idx, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ptr_q          <= GW'(NUM_REQ - 1);
      to_q           <= '0;
      req_ready_q    <= '0;
      uart_tx_en_q   <= 1'b0;
      uart_tx_data_q <= '0;
      grant_id_q     <= '0;
      arb_busy_q     <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      uart_tx_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A busy transmitter (ours or a frame left over from before reset) blocks grants.
          if (win_found && !uart_tx_busy) begin
            req_ready_q    <= win_onehot;
            uart_tx_data_q <= win_data;
            grant_id_q     <= win_idx;
            ptr_q          <= win_idx;
            arb_busy_q     <= 1'b1;
            state_q        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          uart_tx_en_q <= 1'b1;
          state_q      <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (uart_tx_busy) begin
            to_q    <= '0;
            state_q <= ST_WAIT_DONE;
          end else if (to_q == CW'(BUSY_TIMEOUT - 1)) begin
            // Transmitter never answered: drop the byte and flag it.
            to_q          <= '0;
            err_timeout_q <= 1'b1;
            arb_busy_q    <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            to_q <= to_q + CW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!uart_tx_busy) begin
            arb_busy_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          arb_busy_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign uart_tx_en   = uart_tx_en_q;
  assign uart_tx_data = uart_tx_data_q;
  assign grant_id     = grant_id_q;
  assign arb_busy     = arb_busy_q;
  assign err_timeout  = err_timeout_q;

endmodule
